fft_zero_pad_stream: RTL and testbench

//  Streaming zero-padder on the input side of the FFT convolution path.

---
 rtl/fft_zero_pad_stream.sv | 104 ++++++++++
 tb/tb_fft_zero_pad_stream.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_zero_pad_stream.sv
// Streaming zero-padder: SIZE x SIZE raster tile in, (2*SIZE-1)^2 raster frame out, tile placed at (OFF,OFF).
// Latency: one cycle from an accepted input beat to out_data; pad beats are produced without waiting on input.
// Backpressure: out_ready low freezes the output register and the position counters, and in_ready drops.
module fft_zero_pad_stream #(
    parameter int SIZE = 5,
    parameter int DW   = 32,
    parameter int OFF  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic          frame_done,
    output logic          err_last
);

    localparam int PAD = 2 * SIZE - 1;
    localparam int CW  = $clog2(PAD + 1);

    localparam logic [CW-1:0] OFF_C      = CW'(OFF);
    localparam logic [CW-1:0] SIZE_C     = CW'(SIZE);
    localparam logic [CW-1:0] LAST_C     = CW'(PAD - 1);
    localparam logic [CW-1:0] TILE_END_C = CW'(OFF + SIZE - 1);

    // Position of the next beat to be loaded into the output register.
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [CW-1:0] row_nxt;
    logic [CW-1:0] col_nxt;

    logic [CW-1:0] row_rel;
    logic [CW-1:0] col_rel;
    logic          in_win;
    logic          slot_free;
    logic          load;
    logic          at_first;
    logic          at_end;
    logic          at_tile_end;

    // Offset-relative coordinates wrap to a large value when below OFF,
    // so a single unsigned compare covers both window bounds.
    assign row_rel = row - OFF_C;
    assign col_rel = col - OFF_C;
    assign in_win  = (row_rel < SIZE_C) && (col_rel < SIZE_C);

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free && in_win;
    assign load      = slot_free && (!in_win || in_valid);

    assign at_first    = (row == '0) && (col == '0);
    assign at_end      = (row == LAST_C) && (col == LAST_C);
    assign at_tile_end = (row == TILE_END_C) && (col == TILE_END_C);

    always_comb begin
        row_nxt = row;
        col_nxt = col + CW'(1);
        if (col == LAST_C) begin
            col_nxt = '0;
            row_nxt = at_end ? '0 : row + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row        <= '0;
            col        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            err_last   <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_last;

            if (load) begin
                out_data  <= in_win ? in_data : '0;
                out_valid <= 1'b1;
                out_first <= at_first;
                out_last  <= at_end;
                row       <= row_nxt;
                col       <= col_nxt;
            end else if (slot_free) begin
                // Inside the window with no input: emit a bubble, keep position.
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end

            // Sticky; a misplaced in_last does not resync the counters.
            if (in_valid && in_ready && (in_last != at_tile_end)) begin
                err_last <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_zero_pad_stream.sv
// Bench for fft_zero_pad_stream: lane 0 is SIZE=3/OFF=0, lane 1 is SIZE=3/OFF=1; directed tables plus a randomized scoreboard.
module tb_fft_zero_pad_stream;

    localparam int SIZE = 3;
    localparam int PAD  = 2 * SIZE - 1;
    localparam int NBT  = PAD * PAD;

    typedef struct {
        logic [31:0] d;
        logic        f;
        logic        l;
    } beat_t;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ordy;
        logic        irdy;
        logic        ov;
        logic [31:0] od;
        logic        of;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data    [2];
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic        in_last    [2];
    logic [31:0] out_data   [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic        out_first  [2];
    logic        out_last   [2];
    logic        frame_done [2];
    logic        err_last   [2];

    int    pass_cnt = 0;
    int    chk_cnt  = 0;
    beat_t exp_q [2][$];
    logic  err_exp  [2];
    logic  drv_done [2];
    logic  sb_en = 1'b0;
    logic  done_exp [2];
    logic  hold_v   [2];
    logic [31:0] hold_d [2];
    vec_t  tbl [16];
    logic [31:0] t_seq [9];
    logic [31:0] t_rnd [9];

    always #5 clk = ~clk;

    fft_zero_pad_stream #(.SIZE(SIZE), .DW(32), .OFF(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_last(in_last[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_first(out_first[0]), .out_last(out_last[0]),
        .frame_done(frame_done[0]), .err_last(err_last[0])
    );

    fft_zero_pad_stream #(.SIZE(SIZE), .DW(32), .OFF(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_last(in_last[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_first(out_first[1]), .out_last(out_last[1]),
        .frame_done(frame_done[1]), .err_last(err_last[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Lane index doubles as the tile offset.
    function automatic logic win(input int off, input int b);
        int r = b / PAD;
        int c = b % PAD;
        return (r >= off) && (r < off + SIZE) && (c >= off) && (c < off + SIZE);
    endfunction

    task automatic push_frame(input int lane, input logic [31:0] tile [9]);
        beat_t e;
        for (int p = 0; p < NBT; p++) begin
            e.d = win(lane, p) ? tile[(p / PAD - lane) * SIZE + (p % PAD - lane)] : 32'd0;
            e.f = (p == 0);
            e.l = (p == NBT - 1);
            exp_q[lane].push_back(e);
        end
    endtask

    task automatic check_zero(input int lane);
        chk("rst_out_valid", out_valid[lane], 0);
        chk("rst_out_data", out_data[lane], 0);
        chk("rst_out_first", out_first[lane], 0);
        chk("rst_out_last", out_last[lane], 0);
        chk("rst_frame_done", frame_done[lane], 0);
        chk("rst_err_last", err_last[lane], 0);
    endtask

    task automatic do_reset(input logic check);
        rst = 1'b1;
        for (int l = 0; l < 2; l++) begin
            in_valid[l] = 0; in_data[l] = 0; in_last[l] = 0; out_ready[l] = 1;
            exp_q[l].delete();
            err_exp[l] = 0; drv_done[l] = 0; done_exp[l] = 0; hold_v[l] = 0; hold_d[l] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        if (check) begin
            check_zero(0);
            check_zero(1);
        end
    endtask

    // Holds in_valid high, out_ready high; checks every beat against the padded-frame model.
    task automatic run_frame(input int lane, input logic [31:0] tile [9], input int nbeats,
                             input int last_idx, input logic done_first);
        int    idx = 0;
        logic  acc;
        beat_t e;
        push_frame(lane, tile);
        out_ready[lane] = 1;
        for (int b = 0; b < nbeats; b++) begin
            in_valid[lane] = (idx < 9);
            in_data[lane]  = (idx < 9) ? tile[idx] : 32'd0;
            in_last[lane]  = (idx == last_idx);
            @(negedge clk);
            acc = in_ready[lane];
            chk("in_ready", acc, win(lane, b));
            @(posedge clk);
            #1;
            if (acc && in_valid[lane]) begin
                if ((idx == last_idx) != (idx == 8)) err_exp[lane] = 1;
                idx++;
            end
            e = exp_q[lane].pop_front();
            chk("beat_valid", out_valid[lane], 1);
            chk("beat_data", out_data[lane], e.d);
            chk("beat_first", out_first[lane], e.f);
            chk("beat_last", out_last[lane], e.l);
            chk("beat_frame_done", frame_done[lane], (b == 0) ? done_first : 1'b0);
            chk("beat_err_last", err_last[lane], err_exp[lane]);
        end
        in_valid[lane] = 0;
        in_last[lane]  = 0;
    endtask

    task automatic tail_done(input int lane);
        in_valid[lane] = 0;
        @(posedge clk);
        #1;
        chk("tail_frame_done", frame_done[lane], 1);
    endtask

    task automatic rand_drive(input int lane, input int nfr);
        logic [31:0] tile [9];
        logic acc;
        int   n;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < 9; k++) tile[k] = $urandom();
            push_frame(lane, tile);
            for (int k = 0; k < 9; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid[lane] = 0;
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid[lane] = 1;
                in_data[lane]  = tile[k];
                in_last[lane]  = (k == 8);
                n = 0;
                do begin
                    @(negedge clk);
                    acc = in_ready[lane];
                    @(posedge clk);
                    #1;
                    n++;
                end while (!acc && n < 200);
                if (!acc) begin
                    chk("in_accept_timeout", 0, 1);
                    in_valid[lane] = 0;
                    drv_done[lane] = 1;
                    return;
                end
            end
        end
        in_valid[lane] = 0;
        in_last[lane]  = 0;
        drv_done[lane] = 1;
    endtask

    task automatic rdy_drive(input int lane);
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            if (drv_done[lane] && exp_q[lane].size() == 0) begin
                out_ready[lane] = 0;
                return;
            end
            out_ready[lane] = ($urandom_range(0, 3) != 0);
        end
        chk("drain_timeout", exp_q[lane].size(), 0);
        out_ready[lane] = 0;
    endtask

    always @(negedge clk) begin
        if (sb_en && !rst) begin
            for (int l = 0; l < 2; l++) begin
                beat_t e;
                logic  acc;
                chk("sb_frame_done", frame_done[l], done_exp[l]);
                if (hold_v[l]) begin
                    chk("sb_hold_valid", out_valid[l], 1);
                    chk("sb_hold_data", out_data[l], hold_d[l]);
                end
                acc = out_valid[l] && out_ready[l];
                done_exp[l] = 0;
                if (acc) begin
                    if (exp_q[l].size() == 0) begin
                        chk("sb_unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q[l].pop_front();
                        chk("sb_data", out_data[l], e.d);
                        chk("sb_first", out_first[l], e.f);
                        chk("sb_last", out_last[l], e.l);
                        done_exp[l] = e.l;
                    end
                end
                hold_v[l] = out_valid[l] && !out_ready[l];
                hold_d[l] = out_data[l];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        // v, in_data, out_ready | in_ready, out_valid, out_data, out_first  (lane 0, OFF=0)
        tbl[0]  = '{1'b1, 32'd1, 1'b1, 1'b1, 1'b1, 32'd1, 1'b1};
        tbl[1]  = '{1'b1, 32'd2, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0};
        tbl[2]  = '{1'b1, 32'd3, 1'b1, 1'b1, 1'b1, 32'd3, 1'b0};
        tbl[3]  = '{1'b1, 32'd4, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0};
        tbl[4]  = '{1'b1, 32'd4, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0};
        tbl[5]  = '{1'b0, 32'd4, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
        tbl[6]  = '{1'b0, 32'd4, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
        tbl[7]  = '{1'b0, 32'd4, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
        tbl[8]  = '{1'b1, 32'd4, 1'b1, 1'b1, 1'b1, 32'd4, 1'b0};
        tbl[9]  = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 32'd4, 1'b0};
        tbl[10] = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 32'd4, 1'b0};
        tbl[11] = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 32'd4, 1'b0};
        tbl[12] = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 32'd4, 1'b0};
        tbl[13] = '{1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 32'd5, 1'b0};
        tbl[14] = '{1'b1, 32'd6, 1'b1, 1'b1, 1'b1, 32'd6, 1'b0};
        tbl[15] = '{1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0};
        for (int i = 0; i < 9; i++) t_seq[i] = 32'(i + 1);
        for (int i = 0; i < 9; i++) t_rnd[i] = $urandom();

        do_reset(1'b1);

        // Starvation and backpressure at the start of a frame.
        for (int i = 0; i < 16; i++) begin
            in_valid[0]  = tbl[i].v;
            in_data[0]   = tbl[i].d;
            out_ready[0] = tbl[i].ordy;
            @(negedge clk);
            chk("tbl_in_ready", in_ready[0], tbl[i].irdy);
            @(posedge clk);
            #1;
            chk("tbl_out_valid", out_valid[0], tbl[i].ov);
            chk("tbl_out_data", out_data[0], tbl[i].od);
            chk("tbl_out_first", out_first[0], tbl[i].of);
        end

        // Two back-to-back frames with no gap, OFF=0.
        do_reset(1'b0);
        run_frame(0, t_seq, NBT, 8, 1'b0);
        run_frame(0, t_rnd, NBT, 8, 1'b1);
        tail_done(0);

        // OFF=1: six leading pad beats with in_ready low.
        do_reset(1'b0);
        run_frame(1, t_seq, NBT, 8, 1'b0);
        tail_done(1);

        // Misplaced in_last sets a sticky error; only reset clears it.
        do_reset(1'b0);
        run_frame(0, t_seq, NBT, 4, 1'b0);
        run_frame(0, t_rnd, NBT, 8, 1'b1);
        tail_done(0);
        do_reset(1'b1);

        // Reset mid-frame, then a clean frame from (0,0).
        run_frame(0, t_rnd, 12, 8, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero(0);
        rst = 1'b0;
        exp_q[0].delete();
        err_exp[0] = 0;
        run_frame(0, t_seq, NBT, 8, 1'b0);
        tail_done(0);

        // Randomized traffic on both lanes against the scoreboard.
        do_reset(1'b0);
        sb_en = 1'b1;
        fork
            rand_drive(0, 6);
            rand_drive(1, 6);
            rdy_drive(0);
            rdy_drive(1);
        join
        @(posedge clk);
        #1;
        sb_en = 1'b0;
        chk("rand_err_last0", err_last[0], 0);
        chk("rand_err_last1", err_last[1], 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
